// File: rtl/mem_arbiter.sv
// Arbitrates a single-port RAM between instruction fetch and data load/store.
// Data requests win over instruction requests; each access can time out.
module mem_arbiter #(
    parameter int TIMEOUT_CYC = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic [31:0] iload,
    output logic        dhit,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ack,
    output logic        err
);

    // state | meaning
    // IDLE  | no access in flight, sampling requests
    // DATA  | data load/store driving the RAM
    // INSTR | instruction fetch driving the RAM
    // RESP  | one-cycle hit pulse to the requester
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DATA  = 2'd1;
    localparam logic [1:0] INSTR = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam int          CNT_W    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [31:0] BAD_WORD = 32'hBAD1_BAD1;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      lat_addr;
    logic [31:0]      lat_data;
    logic             lat_wr;
    logic             resp_data;
    logic [31:0]      iload_q;
    logic [31:0]      dload_q;
    logic             err_q;

    logic in_access;
    logic req_live;

    assign in_access = (state == DATA) || (state == INSTR);
    assign req_live  = (state == DATA) ? (dREN | dWEN) : iREN;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_wr    <= 1'b0;
            resp_data <= 1'b0;
            iload_q   <= '0;
            dload_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dREN || dWEN) begin
                        state     <= DATA;
                        lat_addr  <= daddr;
                        lat_data  <= dstore;
                        lat_wr    <= dWEN;
                        resp_data <= 1'b1;
                        cnt       <= '0;
                    end else if (iREN) begin
                        state     <= INSTR;
                        lat_addr  <= iaddr;
                        lat_data  <= '0;
                        lat_wr    <= 1'b0;
                        resp_data <= 1'b0;
                        cnt       <= '0;
                    end
                end
                DATA, INSTR: begin
                    // ack beats both a dropped request and counter expiry
                    if (ram_ack) begin
                        state <= RESP;
                        if (!lat_wr) begin
                            if (state == DATA) dload_q <= ramload;
                            else               iload_q <= ramload;
                        end
                    end else if (!req_live) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= RESP;
                        err_q <= 1'b1;
                        if (!lat_wr) begin
                            if (state == DATA) dload_q <= BAD_WORD;
                            else               iload_q <= BAD_WORD;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ramREN   = in_access && !lat_wr;
    assign ramWEN   = in_access && lat_wr;
    assign ramaddr  = in_access ? lat_addr : '0;
    assign ramstore = in_access ? lat_data : '0;

    assign ihit  = (state == RESP) && !resp_data;
    assign dhit  = (state == RESP) && resp_data;
    assign iload = iload_q;
    assign dload = dload_q;
    assign err   = err_q;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The module SHALL have parameter TIMEOUT_CYC, default 16, the maximum cycles a RAM access waits for ram_ack.
REQ-002 CLK  in  1  single clock; all state changes on its rising edge.
REQ-003 RST  in  1  reset, asynchronous and active-high.
REQ-004 iREN  in  1  instruction-fetch request from datapath, held until ihit.
REQ-005 iaddr  in  32  instruction address.
REQ-006 dREN  in  1  data-load request, held until dhit.
REQ-007 dWEN  in  1  data-store request, held until dhit.
REQ-008 daddr  in  32  data address.
REQ-009 dstore  in  32  store data.
REQ-010 ihit  out  1  one-cycle pulse: instruction access complete.
REQ-011 iload  out  32  fetched instruction.
REQ-012 dhit  out  1  one-cycle pulse: data access complete.
REQ-013 dload  out  32  loaded data.
REQ-014 ramREN  out  1  RAM read strobe.
REQ-015 ramWEN  out  1  RAM write strobe.
REQ-016 ramaddr  out  32  RAM address.
REQ-017 ramstore  out  32  RAM write data.
REQ-018 ramload  in  32  RAM read data, valid when ram_ack is high.
REQ-019 ram_ack  in  1  RAM access complete this cycle.
REQ-020 err  out  1  sticky timeout flag.

Function
REQ-021 FSM states SHALL be IDLE, DATA, INSTR, RESP.
REQ-022 IDLE: if dREN or dWEN, go DATA; else if iREN, go INSTR; else stay; data SHALL have priority over instruction.
REQ-023 On leaving IDLE, the address, store data, and operation (write if dWEN, else read) SHALL be latched; dWEN and dREN both high SHALL be a write.
REQ-024 In DATA/INSTR: ramaddr = latched address, ramREN = latched read, ramWEN = latched write, ramstore = latched data; all RAM strobes SHALL be 0 in IDLE and RESP.
REQ-025 In DATA/INSTR, ram_ack high SHALL move to RESP and capture ramload into dload (DATA, read) or iload (INSTR); a write SHALL leave dload unchanged.
REQ-026 In RESP: dhit=1 if entered from DATA, else ihit=1, for exactly one cycle; next state IDLE unconditionally; requests in RESP SHALL be ignored.
REQ-027 Latency: request sampled in IDLE at edge 0; strobes high from cycle 1; ack in cycle k SHALL give hit in cycle k+1; minimum request-to-hit 2 cycles.
REQ-028 ihit and dhit SHALL never be high in the same cycle; iload/dload SHALL hold their value between hits.
REQ-029 A wait counter SHALL clear on entering DATA/INSTR and increment each cycle there without ack.
REQ-030 If the counter reaches TIMEOUT_CYC-1 without ack: go RESP, load 32'hBAD1BAD1 into the relevant load register (reads only), set err=1 until reset; the hit pulse SHALL still be issued.
REQ-031 If the initiating request drops in DATA/INSTR before ack (dREN|dWEN low for DATA, iREN low for INSTR), the FSM SHALL return to IDLE, no hit, load registers unchanged.
REQ-032 ram_ack in the same cycle as a request drop SHALL take priority: complete normally to RESP.
REQ-033 ram_ack in the same cycle as counter expiry SHALL be treated as a normal ack; err SHALL not set.

Reset
REQ-034 RST high SHALL immediately force IDLE, counter 0, ihit=dhit=0, iload=dload=0, err=0, latched address/data/op 0, so all RAM strobes 0 regardless of CLK.
REQ-035 RST asserted mid-access SHALL abandon the access with no hit pulse after release.

Verification
REQ-036 iREN=1, iaddr=0x40; ram_ack high 3 cycles after ramREN rises with ramload=0x20010005 -> ihit one cycle later, iload=0x20010005, dhit=0.
REQ-037 iREN and dREN high together in IDLE, daddr=0x100 -> ramaddr=0x100 first; dhit issued; then INSTR serviced with ramaddr=iaddr.
REQ-038 dWEN=dREN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dhit after ack; dload unchanged.
REQ-039 dREN=1, ram_ack never asserted, TIMEOUT_CYC=16 -> dhit 16 cycles after DATA entry, dload=0xBAD1BAD1, err=1 held until RST.
REQ-040 RST pulsed while in DATA with ramREN=1 -> ramREN falls asynchronously, no dhit afterward, dload=0, err=0.
